// File: rtl/rv32i_types.sv
// rv32i_types: shared types for the memory hierarchy (line width, arbiter grant).
package rv32i_types;
  localparam int LINE_W = 256;
  typedef enum logic {GRANT_I, GRANT_D} arb_grant_t;
endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one physical memory port between the I-side (read-only) and D-side
// requesters, one transaction at a time, round-robin on simultaneous requests.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int DATA_W = LINE_W,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [DATA_W-1:0] pmem_wdata,
  input  logic [DATA_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);
  typedef enum logic [1:0] {s_idle, s_inst, s_data} state_t;
  state_t     state;
  arb_grant_t last_grant;
  logic       i_req, d_req, in_i, in_d;
  assign i_req = i_read;
  assign d_req = d_read | d_write;
  assign in_i  = state == s_inst;
  assign in_d  = state == s_data;
  // every s_idle pass is mandatory, so grants can never run back to back
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= s_idle;
      last_grant <= GRANT_I;
    end else begin
      case (state)
        s_idle: begin
          if (i_req && d_req) state <= (last_grant == GRANT_I) ? s_data : s_inst;
          else if (i_req) state <= s_inst;
          else if (d_req) state <= s_data;
        end
        s_inst: if (pmem_resp) begin
          state      <= s_idle;
          last_grant <= GRANT_I;
        end
        s_data: if (pmem_resp) begin
          state      <= s_idle;
          last_grant <= GRANT_D;
        end
        default: state <= s_idle;
      endcase
    end
  end
  // a simultaneous read+write from D is treated as a write
  assign pmem_read    = in_i | (in_d & d_read & ~d_write);
  assign pmem_write   = in_d & d_write;
  assign pmem_address = in_i ? i_address : in_d ? d_address : '0;
  assign pmem_wdata   = in_d ? d_wdata : '0;
  assign i_rdata      = in_i ? pmem_rdata : '0;
  assign d_rdata      = in_d ? pmem_rdata : '0;
  assign i_resp       = in_i & pmem_resp;
  assign d_resp       = in_d & pmem_resp;
endmodule
